// File: rtl/imm_pkg.sv
// imm_pkg: shared types and constants for the immediate generator.
//   imm_fmt_e    - format code driven on out_fmt
//   skid_state_e - occupancy of the two-entry output skid buffer
//   imm_entry_t  - one decoded result: immediate, format, tag, illegal flag
// The struct fields are sized for the widest legal configuration
// (64-bit immediate, 64-bit tag). Narrower instances use the low bits, so
// TAG_W of the top level must not exceed TAG_MAX.
package imm_pkg;

    localparam int IMM_MAX = 64;
    localparam int TAG_MAX = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_R    = 3'd6
    } imm_fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [IMM_MAX-1:0] imm;
        imm_fmt_e           fmt;
        logic [TAG_MAX-1:0] tag;
        logic               illegal;
    } imm_entry_t;

    localparam imm_entry_t ENTRY_RESET = '{imm: '0, fmt: FMT_NONE, tag: '0, illegal: 1'b0};

    // Major opcodes, instruction bits [6:0]
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: purely combinational immediate decode of one instruction word.
// Ports:
//   instr  in  32           raw instruction word
//   entry  out imm_entry_t  decoded immediate (sign-extended to 64 bits;
//                           the caller keeps the low XLEN bits), format and
//                           illegal flag; the tag field is left at zero
// Parameter XLEN (32 or 64) selects the RV64-only opcodes and shamt width.
// Optional macro RVC_IMM_EN: decode 16-bit compressed encodings
// (instr[1:0] != 2'b11); without it such words are flagged illegal.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr,
    output imm_entry_t  entry
);

    localparam bit IS64 = (XLEN == 64);

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_b;
    logic [63:0] imm_u;
    logic [63:0] imm_j;
    logic        is_shift;

    assign opc    = instr[6:0];
    assign funct3 = instr[14:12];

    // Every 32-bit format sign-extends from instruction bit 31
    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // SLLI/SRLI/SRAI: funct7 lives in the upper immediate bits, only shamt counts
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

`ifdef RVC_IMM_EN
    // Compressed decode: only the low halfword is meaningful.
    function automatic imm_entry_t decode_rvc(input logic [15:0] c);
        imm_entry_t e;
        e         = ENTRY_RESET;
        e.illegal = 1'b1;
        case ({c[1:0], c[15:13]})
            5'b01_000, 5'b01_010: begin          // C.ADDI, C.LI
                e.imm     = {{58{c[12]}}, c[12], c[6:2]};
                e.fmt     = FMT_I;
                e.illegal = 1'b0;
            end
            5'b01_011: begin                     // C.LUI (rd=2 is C.ADDI16SP, zero nzimm reserved)
                if (c[11:7] != 5'd2 && {c[12], c[6:2]} != 6'd0) begin
                    e.imm     = {{46{c[12]}}, c[12], c[6:2], 12'b0};
                    e.fmt     = FMT_U;
                    e.illegal = 1'b0;
                end
            end
            5'b00_010: begin                     // C.LW
                e.imm     = {57'b0, c[5], c[12:10], c[6], 2'b0};
                e.fmt     = FMT_I;
                e.illegal = 1'b0;
            end
            5'b00_110: begin                     // C.SW
                e.imm     = {57'b0, c[5], c[12:10], c[6], 2'b0};
                e.fmt     = FMT_S;
                e.illegal = 1'b0;
            end
            5'b01_101: begin                     // C.J
                e.imm     = {{52{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
                e.fmt     = FMT_J;
                e.illegal = 1'b0;
            end
            5'b01_110, 5'b01_111: begin          // C.BEQZ, C.BNEZ
                e.imm     = {{55{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
                e.fmt     = FMT_B;
                e.illegal = 1'b0;
            end
            default: ;
        endcase
        return e;
    endfunction
`endif

    always_comb begin
        entry         = ENTRY_RESET;
        entry.illegal = 1'b1;
        if (instr[1:0] == 2'b11) begin
            case (opc)
                OPC_OP_IMM: begin
                    entry.fmt     = FMT_I;
                    entry.illegal = 1'b0;
                    if (is_shift)
                        entry.imm = IS64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
                    else
                        entry.imm = imm_i;
                end
                OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                    entry.imm     = imm_i;
                    entry.fmt     = FMT_I;
                    entry.illegal = 1'b0;
                end
                OPC_OP_IMM_32: begin
                    // Word shifts always take a 5-bit shamt
                    if (IS64) begin
                        entry.imm     = is_shift ? {59'b0, instr[24:20]} : imm_i;
                        entry.fmt     = FMT_I;
                        entry.illegal = 1'b0;
                    end
                end
                OPC_STORE: begin
                    entry.imm     = imm_s;
                    entry.fmt     = FMT_S;
                    entry.illegal = 1'b0;
                end
                OPC_BRANCH: begin
                    entry.imm     = imm_b;
                    entry.fmt     = FMT_B;
                    entry.illegal = 1'b0;
                end
                OPC_LUI, OPC_AUIPC: begin
                    entry.imm     = imm_u;
                    entry.fmt     = FMT_U;
                    entry.illegal = 1'b0;
                end
                OPC_JAL: begin
                    entry.imm     = imm_j;
                    entry.fmt     = FMT_J;
                    entry.illegal = 1'b0;
                end
                OPC_OP: begin
                    entry.fmt     = FMT_R;
                    entry.illegal = 1'b0;
                end
                OPC_OP_32: begin
                    if (IS64) begin
                        entry.fmt     = FMT_R;
                        entry.illegal = 1'b0;
                    end
                end
                default: ;
            endcase
        end else begin
`ifdef RVC_IMM_EN
            entry = decode_rvc(instr[15:0]);
`endif
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a two-entry skid buffer.
// Ports:
//   clk, rst (async, active high)
//   in_valid / in_ready / in_instr / in_tag        upstream handshake
//   out_valid / out_ready / out_imm / out_fmt /
//   out_tag / out_illegal                          downstream handshake
// Parameters: XLEN (32 or 64), TAG_W (<= imm_pkg::TAG_MAX).
// Optional macro RVC_IMM_EN enables compressed decode inside imm_decode.
// Decode happens on the input side so each held entry is already final;
// in_ready and out_valid are registers, so there is no combinational path
// from out_ready back to in_ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    imm_entry_t  dec_raw;
    imm_entry_t  dec_entry;
    imm_entry_t  main_reg;
    imm_entry_t  skid_reg;
    skid_state_e state_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic        in_xfer;
    logic        out_xfer;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .entry (dec_raw)
    );

    always_comb begin
        dec_entry     = dec_raw;
        dec_entry.tag = TAG_MAX'(in_tag);
    end

    assign in_xfer  = in_valid && in_ready_reg;
    assign out_xfer = out_valid_reg && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            main_reg      <= ENTRY_RESET;
            skid_reg      <= ENTRY_RESET;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    // in_ready is held low through reset and rises on the first edge after
                    in_ready_reg <= 1'b1;
                    if (in_xfer) begin
                        main_reg      <= dec_entry;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_reg     <= dec_entry;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_FULL;
                    end else if (in_xfer && out_xfer) begin
                        main_reg <= dec_entry;
                    end else if (out_xfer) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the output side can move
                    if (out_xfer) begin
                        main_reg     <= skid_reg;
                        in_ready_reg <= 1'b1;
                        state_reg    <= ST_ONE;
                    end
                end
                default: begin
                    state_reg     <= ST_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_imm     = main_reg.imm[XLEN-1:0];
    assign out_fmt     = main_reg.fmt;
    assign out_tag     = main_reg.tag[TAG_W-1:0];
    assign out_illegal = main_reg.illegal;

    // Upper struct bits are unused in narrow configurations
    logic unused_bits;
    assign unused_bits = ^{main_reg.imm, main_reg.tag, dec_raw.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: a 32-bit and a 64-bit instance are driven with the
// same stimulus; expected results come from a constant vector table and are
// tracked through a scoreboard queue in acceptance order.
module tb_imm_gen_pipe;

    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                           F_U = 3'd4, F_J = 3'd5, F_R = 3'd6;
    localparam int NV = 17;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] tag;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_ready;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_tag;
    logic [2:0]  out_fmt;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;
    logic [2:0]  out_fmt64;

    vec_t vec [NV];
    sb_t  q [$];
    int   cur_idx;
    int   tests = 0;
    int   fails = 0;
    bit   rand_mode = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int idx, input logic [31:0] tag);
        in_valid = 1'b1;
        in_instr = vec[idx].instr;
        in_tag   = tag;
        cur_idx  = idx;
    endtask

    // Present one word and return just after the edge that accepted it.
    task automatic send(input int idx, input logic [31:0] tag);
        bit ok;
        int n;
        drive(idx, tag);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (!ok) check("send_timeout", 64'(n), 64'd0);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    // Scoreboard: push on input transfer, compare head while out_valid, pop on output transfer.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (in_valid && in_ready) q.push_back('{idx: cur_idx, tag: in_tag});
            if (q.size() == 0) begin
                check("no_unexpected_out_valid", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                sb_t e;
                e = q[0];
                check($sformatf("imm32[%0d]", e.idx), 64'(out_imm), 64'(vec[e.idx].imm32));
                check($sformatf("fmt32[%0d]", e.idx), 64'(out_fmt), 64'(vec[e.idx].fmt32));
                check($sformatf("ill32[%0d]", e.idx), 64'(out_illegal), 64'(vec[e.idx].ill32));
                check($sformatf("tag32[%0d]", e.idx), 64'(out_tag), 64'(e.tag));
                check($sformatf("valid64[%0d]", e.idx), 64'(out_valid64), 64'd1);
                check($sformatf("imm64[%0d]", e.idx), out_imm64, vec[e.idx].imm64);
                check($sformatf("fmt64[%0d]", e.idx), 64'(out_fmt64), 64'(vec[e.idx].fmt64));
                check($sformatf("ill64[%0d]", e.idx), 64'(out_illegal64), 64'(vec[e.idx].ill64));
                check($sformatf("tag64[%0d]", e.idx), 64'(out_tag64), 64'(e.tag));
                if (out_ready) begin
                    $display("[TB] out instr=%08h tag=%08h imm32=%08h imm64=%016h fmt=%0d ill=%0d",
                             vec[e.idx].instr, out_tag, out_imm, out_imm64, out_fmt, out_illegal);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          instr          imm32         fmt32  ill   imm64                    fmt64  ill
        vec[0]  = '{32'hFFF00093, 32'hFFFFFFFF, F_I,  1'b0, 64'hFFFFFFFFFFFFFFFF, F_I,  1'b0};
        vec[1]  = '{32'h123450B7, 32'h12345000, F_U,  1'b0, 64'h0000000012345000, F_U,  1'b0};
        vec[2]  = '{32'h00000463, 32'h00000008, F_B,  1'b0, 64'h0000000000000008, F_B,  1'b0};
        vec[3]  = '{32'hFFDFF06F, 32'hFFFFFFFC, F_J,  1'b0, 64'hFFFFFFFFFFFFFFFC, F_J,  1'b0};
        vec[4]  = '{32'h4030D093, 32'h00000003, F_I,  1'b0, 64'h0000000000000003, F_I,  1'b0};
        vec[5]  = '{32'h02101093, 32'h00000001, F_I,  1'b0, 64'h0000000000000021, F_I,  1'b0};
        vec[6]  = '{32'h0000007F, 32'h00000000, F_NONE, 1'b1, 64'h0, F_NONE, 1'b1};
        vec[7]  = '{32'hFE20AC23, 32'hFFFFFFF8, F_S,  1'b0, 64'hFFFFFFFFFFFFFFF8, F_S,  1'b0};
        vec[8]  = '{32'h002081B3, 32'h00000000, F_R,  1'b0, 64'h0, F_R,  1'b0};
        vec[9]  = '{32'h0000003B, 32'h00000000, F_NONE, 1'b1, 64'h0, F_R,  1'b0};
        vec[10] = '{32'h0010009B, 32'h00000000, F_NONE, 1'b1, 64'h1, F_I,  1'b0};
        vec[11] = '{32'h80000037, 32'h80000000, F_U,  1'b0, 64'hFFFFFFFF80000000, F_U,  1'b0};
        vec[12] = '{32'h80002083, 32'hFFFFF800, F_I,  1'b0, 64'hFFFFFFFFFFFFF800, F_I,  1'b0};
        vec[13] = '{32'h00000073, 32'h00000000, F_I,  1'b0, 64'h0, F_I,  1'b0};
        vec[14] = '{32'hFFF00090, 32'h00000000, F_NONE, 1'b1, 64'h0, F_NONE, 1'b1};
`ifdef RVC_IMM_EN
        vec[15] = '{32'h0000557D, 32'hFFFFFFFF, F_I,  1'b0, 64'hFFFFFFFFFFFFFFFF, F_I,  1'b0};
        vec[16] = '{32'h00004040, 32'h00000004, F_I,  1'b0, 64'h0000000000000004, F_I,  1'b0};
`else
        vec[15] = '{32'h0000557D, 32'h00000000, F_NONE, 1'b1, 64'h0, F_NONE, 1'b1};
        vec[16] = '{32'h00004040, 32'h00000000, F_NONE, 1'b1, 64'h0, F_NONE, 1'b1};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        cur_idx   = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_in_ready64", 64'(in_ready64), 64'd0);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_out_fmt", 64'(out_fmt), 64'(F_NONE));
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_release", 64'(in_ready), 64'd1);
        check("out_valid_after_release", 64'(out_valid), 64'd0);

        // Table, streaming with downstream always ready
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) send(i, 32'h1000_0000 + 32'(i));
        drain();

        // Table again under random downstream stalls
        rand_mode = 1'b1;
        for (int i = 0; i < NV; i++) send(i, 32'h2000_0000 + 32'(i));
        rand_mode = 1'b0;
        drain();

        // Backpressure: in_ready drops after the second accept, order is kept
        out_ready = 1'b0;
        drive(0, 32'h3000_0000);
        @(negedge clk);
        check("bp_in_ready_first", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive(1, 32'h3000_0001);
        @(negedge clk);
        check("bp_in_ready_second", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive(2, 32'h3000_0002);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready_full", 64'(in_ready), 64'd0);
            check("bp_out_valid_stalled", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(2, 32'h3000_0002);
        send(3, 32'h3000_0003);
        drain();

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        send(4, 32'h4000_0000);
        send(5, 32'h4000_0001);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_valid64", 64'(out_valid64), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("postrst_no_stale_valid", 64'(out_valid), 64'd0);
        send(6, 32'h5000_0006);
        send(11, 32'h5000_000B);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
